ctrl_uart_rx: RTL and testbench
===============================

# ctrl_uart_rx

Receive-side counterpart of the burst UART transmitter: deserialises 8N1 bytes from the board `rx` pin and assembles them into a 400-bit frame buffer until the terminator byte 0xF0. It then presents the payload and byte count with a one-cycle `valid` strobe. It sits between the external UART pin and the consuming control logic, and packs the payload exactly as the transmitter consumes it: first byte in the top octet.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 115200, line rate; bit period `DIV = CLK_HZ/BAUD` (rounded to nearest, 434 at defaults).
- `MAX_BYTES`, 50, payload capacity in bytes (400 bits / 8).
- `TERM`, 8'hF0, frame terminator byte.
- `TIMEOUT_BITS`, 40, maximum idle gap inside a frame, in bit periods.
- `clk_50`, in, 1, system clock; single clock domain.
- `rst`, in, 1, synchronous, active-high reset.
- `rx`, in, 1, asynchronous serial input; idles high.
- `data`, out, 400, received payload. Byte k is at `[399-8k -: 8]`; unused bytes are 0.
- `num`, out, 6, payload byte count, 0..50, excluding the terminator.
- `valid`, out, 1, one-cycle pulse when `data`/`num` update.
- `busy`, out, 1, high while a frame is being received.
- `err`, out, 1, one-cycle pulse when a frame is discarded.

## Operation
- `rx` passes through a 2-FF synchroniser before any use.
- Byte receiver (`urx`):
  - Detects a falling edge and re-checks low at DIV/2; a high sample there is a glitch, so it returns to idle.
  - Samples 8 data bits LSB-first at the centre of each bit period, then samples the stop bit.
  - Pulses `byte_done` with `byte_out`; pulses `frame_err` instead if the stop bit is 0.
- Frame FSM states: IDLE, COLLECT, HUNT.
- IDLE:
  - `byte_done` with TERM: `valid` pulses with `num=0` and `data=0`.
  - Any other byte: stored at index 0, count=1, go to COLLECT.
- COLLECT:
  - Byte ≠ TERM with count < MAX_BYTES: store at index count, then count+1.
  - TERM: copy the shadow buffer to `data`, set `num=count`, pulse `valid`, go to IDLE.
  - The first TERM always terminates the frame; 0xF0 cannot be carried as payload.
- COLLECT error conditions, each of which pulses `err` and goes to HUNT:
  - A byte ≠ TERM arrives with count == MAX_BYTES (overflow).
  - The receiver reports `frame_err`.
  - The gap counter reaches `TIMEOUT_BITS*DIV` clocks with no `byte_done`.
- HUNT: discard all bytes; a received TERM returns to IDLE with no `valid`.
- The shadow buffer is zeroed on entry to IDLE, so unused bytes of a delivered frame read 0.
- `frame_err` in IDLE or HUNT is ignored; no `err` pulse.
- `busy` = (state != IDLE) or `urx` mid-byte.

## Timing
- Reset values: `data=0`, `num=0`, `valid=0`, `busy=0`, `err=0`. FSM goes to IDLE; count, gap counter and `urx` all clear.
- `rst` in the middle of a byte or frame aborts it with no `valid`/`err`. A partial byte in flight after reset release must not be accepted as a start bit until `rx` has been seen high.
- Synchroniser latency: 2 clocks.
- `byte_done` occurs at the stop-bit centre sample.
- `valid` is registered: it asserts 1 clock after the TERM `byte_done`. `data`/`num` change in that same cycle and then hold until the next `valid`.
- There is no backpressure; the consumer must capture on `valid`.
- `valid` and `err` are never high in the same cycle.
- The gap counter clears on every `byte_done` and only runs in COLLECT.
- Back-to-back frames with zero idle between stop and start bits must be received without loss.
- Count arithmetic is 6-bit; the `count == MAX_BYTES` check happens before the increment, so count never wraps.

## Structure
- Shared package `uart_pkg`:
  - `TERM_BYTE` (8'hF0) and `MAX_BYTES` (50), also used by the transmitter.
  - Function `baud_div(clk_hz, baud)`.
  - FSM state enum.
- Sub-module `urx`: synchroniser, bit timing and 8N1 deserialiser. Ports: `clk_50`, `rst`, `rx`, `byte_out[7:0]`, `byte_done`, `frame_err`, `active`.
- Top level: frame FSM, shadow buffer, gap counter and output registers.

## Test plan
- Send 0x11, 0x22, 0x33, 0xF0 -> one `valid`, `num=3`, `data[399:376]=24'h112233`, `data[375:0]=0`, `busy` low 1 clock after `valid`.
- Send 0xF0 alone -> `valid` with `num=0`, `data=0`. Then send 0xA5, 0xF0 back-to-back -> `num=1`, `data[399:392]=8'hA5`.
- Send 51 bytes 0x01..0x33 then 0xF0 -> `err` pulse on the 51st byte, no `valid`. A following 0x42, 0xF0 frame delivers `num=1`.
- Send 0x55 with stop bit forced 0 mid-frame -> `err`, HUNT; the next TERM returns to IDLE silently.
- Send 0x10, then idle for 41 bit periods -> `err` at 40 bit periods. A later 0xF0 produces no `valid`.
- Assert `rst` for 1 clock during bit 4 of the second byte -> all outputs 0, no `valid`/`err`. The next full frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: framing constants, baud divider helper and FSM encodings.
package uart_pkg;

  localparam logic [7:0]  TERM_BYTE = 8'hF0;
  localparam int unsigned MAX_BYTES = 50;

  // Frame-level receive state
  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StHunt
  } frame_state_e;

  // Byte deserialiser state
  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  // Clocks per bit, rounded to nearest
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/urx.sv
// 8N1 byte receiver: 2-FF synchroniser, start-bit qualification and centre sampling.
module urx #(
  parameter int unsigned DIV = 434
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_done,
  output logic       frame_err,
  output logic       active
);
  import uart_pkg::*;

  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            fall;

  // Synchroniser and edge history; reset low so a line already low after reset
  // cannot look like a falling edge until it has been seen high.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall = rx_prev_q & ~rx_sync_q;

  // Bit-timing and deserialiser state
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: qualify start at half bit, then sample at each bit centre
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (fall) begin
          state_d = RxStart;
        end
      end
      RxStart: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RxStop;
          end
        end
      end
      RxStop: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          state_d = RxIdle;
          done_d  = rx_sync_q;
          ferr_d  = ~rx_sync_q;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_out  = shreg_q;
  assign byte_done = done_q;
  assign frame_err = ferr_q;
  assign active    = (state_q != RxIdle);

endmodule

// File: rtl/ctrl_uart_rx.sv
// Frame receiver: collects bytes into a shadow buffer until TERM, then publishes
// the payload (first byte in the top octet) with a one-cycle valid strobe.
module ctrl_uart_rx #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned MAX_BYTES    = uart_pkg::MAX_BYTES,
  parameter logic [7:0]  TERM         = uart_pkg::TERM_BYTE,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic                   clk_50,
  input  logic                   rst,
  input  logic                   rx,
  output logic [8*MAX_BYTES-1:0] data,
  output logic [5:0]             num,
  output logic                   valid,
  output logic                   busy,
  output logic                   err
);
  import uart_pkg::*;

  localparam int unsigned W            = 8 * MAX_BYTES;
  localparam int unsigned DIV          = uart_pkg::baud_div(CLK_HZ, BAUD);
  localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * DIV;

  logic [7:0]   byte_out;
  logic         byte_done, frame_err, rx_active;

  frame_state_e state_q, state_d;
  logic [5:0]   count_q, count_d;
  logic [31:0]  gap_q, gap_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] data_q, data_d;
  logic [5:0]   num_q, num_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  urx #(
    .DIV(DIV)
  ) u_urx (
    .clk_50   (clk_50),
    .rst      (rst),
    .rx       (rx),
    .byte_out (byte_out),
    .byte_done(byte_done),
    .frame_err(frame_err),
    .active   (rx_active)
  );

  // Frame state, buffers and registered outputs
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      gap_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      num_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      num_q    <= num_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next-state: byte accumulation, termination and error detection
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    gap_d    = (state_q == StCollect) ? gap_q + 32'd1 : 32'd0;
    shadow_d = shadow_q;
    data_d   = data_q;
    num_d    = num_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (byte_done) begin
      gap_d = '0;
    end
    unique case (state_q)
      StIdle: begin
        if (byte_done) begin
          if (byte_out == TERM) begin
            data_d  = '0;
            num_d   = '0;
            valid_d = 1'b1;
          end else begin
            shadow_d[W-1 -: 8] = byte_out;
            count_d            = 6'd1;
            state_d            = StCollect;
          end
        end
      end
      StCollect: begin
        if (byte_done) begin
          if (byte_out == TERM) begin
            data_d   = shadow_q;
            num_d    = count_q;
            valid_d  = 1'b1;
            shadow_d = '0;
            count_d  = '0;
            state_d  = StIdle;
          end else if (count_q == 6'(MAX_BYTES)) begin
            err_d   = 1'b1;
            state_d = StHunt;
          end else begin
            shadow_d[W - 1 - 8 * int'(count_q) -: 8] = byte_out;
            count_d = count_q + 6'd1;
          end
        end else if (frame_err || gap_q == 32'(TIMEOUT_CLKS - 1)) begin
          err_d   = 1'b1;
          state_d = StHunt;
        end
      end
      StHunt: begin
        if (byte_done && byte_out == TERM) begin
          shadow_d = '0;
          count_d  = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data  = data_q;
  assign num   = num_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (state_q != StIdle) || rx_active;

endmodule

// File: tb/tb_ctrl_uart_rx.sv
// Self-checking bench: a frame-level reference model fills an expectation queue as
// stimulus is issued; a monitor pops and compares whenever valid or err fires.
module tb_ctrl_uart_rx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int          DIV    = 10;
  localparam logic [7:0]  TERM   = 8'hF0;
  localparam int          MAXB   = 50;

  logic         clk_50 = 1'b0;
  logic         rst;
  logic         rx;
  logic [399:0] data;
  logic [5:0]   num;
  logic         valid, busy, err;

  ctrl_uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk_50(clk_50),
    .rst   (rst),
    .rx    (rx),
    .data  (data),
    .num   (num),
    .valid (valid),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk_50 = ~clk_50;

  typedef struct {
    bit           is_err;
    logic [5:0]   num;
    logic [399:0] data;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  longint     cyc = 0;
  longint     last_err_cyc = 0;
  bit         busy_chk = 0;

  // Reference model: frame-level mode plus the list of bytes collected so far
  int         mode = 0;  // 0 idle, 1 collecting, 2 hunting
  logic [7:0] mbuf[$];

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_valid();
    exp_t e;
    e.is_err = 0;
    e.num    = 6'(mbuf.size());
    e.data   = '0;
    foreach (mbuf[k]) e.data[399 - 8*k -: 8] = mbuf[k];
    expq.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1;
    e.num    = '0;
    e.data   = '0;
    expq.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      if (mode == 1) begin
        push_err();
        mode = 2;
      end
    end else if (mode == 0) begin
      mbuf.delete();
      if (b == TERM) push_valid();
      else begin
        mbuf.push_back(b);
        mode = 1;
      end
    end else if (mode == 1) begin
      if (b == TERM) begin
        push_valid();
        mode = 0;
      end else if (mbuf.size() == MAXB) begin
        push_err();
        mode = 2;
      end else mbuf.push_back(b);
    end else if (b == TERM) begin
      mode = 0;
    end
  endtask

  task automatic model_gap(input int bits);
    if (mode == 1 && bits > 40) begin
      push_err();
      mode = 2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    model_byte(b, ok);
    rx = 1'b0;
    repeat (DIV) @(negedge clk_50);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk_50);
    end
    rx = ok;
    repeat (DIV) @(negedge clk_50);
    if (!ok) begin
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk_50);
    end
  endtask

  task automatic idle_bits(input int n);
    model_gap(n);
    rx = 1'b1;
    repeat (n * DIV) @(negedge clk_50);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == TERM);
    return b;
  endfunction

  task automatic check_drained(input string name);
    check(name, 400'(expq.size()), 400'd0);
    expq.delete();
  endtask

  // Monitor: every valid/err must match the oldest outstanding expectation
  always @(negedge clk_50) begin
    exp_t e;
    if (busy_chk) begin
      check("busy_after_valid", 400'(busy), 400'd0);
      busy_chk = 0;
    end
    if (!rst && (valid || err)) begin
      check("valid_err_exclusive", 400'(valid & err), 400'd0);
      if (err) last_err_cyc = cyc;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got valid=%0b err=%0b num=%0d expected none",
                 valid, err, num);
      end else begin
        e = expq.pop_front();
        check("output_kind_err", 400'(err), 400'(e.is_err));
        if (!e.is_err) begin
          check("num", 400'(num), 400'(e.num));
          check("data", data, e.data);
          busy_chk = 1;
        end
      end
    end
  end

  initial begin
    longint t0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk_50);
    check("reset_data", data, '0);
    check("reset_flags", 400'({num, valid, busy, err}), 400'd0);
    rst = 1'b0;
    repeat (3 * DIV) @(negedge clk_50);

    // Basic three-byte frame
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(TERM, 1);
    idle_bits(1);
    check_drained("frame_112233");

    // Empty frame then back-to-back single-byte frame
    send_byte(TERM, 1);
    send_byte(8'hA5, 1); send_byte(TERM, 1);
    idle_bits(1);
    check_drained("empty_then_a5");

    // Exactly full frame
    for (int i = 0; i < MAXB; i++) send_byte(rand_byte(), 1);
    send_byte(TERM, 1);
    idle_bits(1);
    check_drained("full_frame");

    // Overflow on byte 51, then recovery
    for (int i = 1; i <= 51; i++) send_byte(8'(i), 1);
    send_byte(TERM, 1);
    send_byte(8'h42, 1); send_byte(TERM, 1);
    idle_bits(1);
    check_drained("overflow_recover");

    // Bad stop bit mid-frame, silent return on TERM, then good frame
    send_byte(8'h11, 1); send_byte(8'h55, 0); send_byte(TERM, 1);
    send_byte(8'h77, 1); send_byte(TERM, 1);
    idle_bits(1);
    check_drained("stop_bit_error");

    // Timeout after 40 idle bit periods inside a frame
    last_err_cyc = 0;
    send_byte(8'h10, 1);
    t0 = cyc;
    idle_bits(41);
    check("timeout_err_window", 400'((last_err_cyc - t0 >= 390 && last_err_cyc - t0 <= 410)),
          400'd1);
    send_byte(TERM, 1);
    idle_bits(1);
    check_drained("timeout");

    // Reset during bit 4 of the second byte (0x0F: line stays low until stop)
    send_byte(8'h21, 1);
    rx = 1'b0;
    repeat (DIV) @(negedge clk_50);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] | 1'b1;
      repeat (DIV) @(negedge clk_50);
    end
    rx = 1'b0;
    repeat (DIV / 2) @(negedge clk_50);
    rst = 1'b1;
    mode = 0;
    mbuf.delete();
    @(negedge clk_50);
    rst = 1'b0;
    check("rst_mid_data", data, '0);
    check("rst_mid_flags", 400'({num, valid, busy, err}), 400'd0);
    repeat (DIV - DIV / 2 - 1 + 3 * DIV) @(negedge clk_50);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk_50);
    check_drained("reset_abort");
    send_byte(8'h99, 1); send_byte(8'h88, 1); send_byte(TERM, 1);
    idle_bits(1);
    check_drained("after_reset");

    // Randomized frames: clean, bad stop bit, or long gap at a random position
    for (int f = 0; f < 10; f++) begin
      int kind, len, pos;
      kind = $urandom_range(0, 2);
      len  = $urandom_range(0, 20);
      pos  = $urandom_range(0, len);
      for (int i = 0; i < len; i++) begin
        if (kind == 2 && i == pos) idle_bits(41);
        send_byte(rand_byte(), !(kind == 1 && i == pos));
        idle_bits($urandom_range(0, 2));
      end
      if (kind == 2 && pos == len) idle_bits(41);
      send_byte(TERM, 1);
      idle_bits($urandom_range(1, 3));
      check_drained("rand_frame");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
